decoder_pipe: RTL and testbench

- Parametrised, handshaked successor to the single-cycle DECODE-state instruction decoder.
- Accepts raw RV32 instruction words plus a tag (PC) over a valid/ready interface and decodes them into a compact op index, register indices, a sign-extended immediate and an illegal flag.
- Results are buffered in a DEPTH-entry output FIFO so fetch and execute are decoupled.
- Sits between fetch and execute; replaces state-gated decoding in the pipelined core.

---
 rtl/decoder_pipe_if.sv | 36 +++
 rtl/decoder_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_decoder_pipe.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pipe_if
//  Brief    : Fetch-side and execute-side handshakes of the decoder pipe.
//  Revision : 1.0 - initial release
// ============================================================================
interface decoder_pipe_if #(
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_op;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pipe
//  Brief    : RV32I(+M) instruction decoder feeding a DEPTH-entry output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_pipe #(
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 32,
    parameter int ENABLE_M = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decoder_pipe_if.slave bus
);
    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [2:0] c_FMT_R  = 3'd0;
    localparam logic [2:0] c_FMT_I  = 3'd1;
    localparam logic [2:0] c_FMT_SH = 3'd2;
    localparam logic [2:0] c_FMT_S  = 3'd3;
    localparam logic [2:0] c_FMT_B  = 3'd4;
    localparam logic [2:0] c_FMT_U  = 3'd5;
    localparam logic [2:0] c_FMT_J  = 3'd6;

    typedef struct packed {
        logic [5:0]       op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [31:0]      imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      w_instr;
    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [5:0]       w_op;
    logic [2:0]       w_fmt;
    logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    entry_t           w_entry;
    entry_t           w_head;
    logic             w_ready, w_valid, w_push, w_pop;

    entry_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    assign w_instr  = bus.in_instr;
    assign w_opc    = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'd0};
    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_imm_sh = {27'd0, w_instr[24:20]};

    // op index stays 0 unless every defined field matches exactly
    always_comb begin
        w_op  = 6'd0;
        w_fmt = c_FMT_R;
        case (w_opc)
            c_OPC_LUI:   begin w_fmt = c_FMT_U; w_op = 6'd1; end
            c_OPC_AUIPC: begin w_fmt = c_FMT_U; w_op = 6'd2; end
            c_OPC_JAL:   begin w_fmt = c_FMT_J; w_op = 6'd3; end
            c_OPC_JALR: begin
                w_fmt = c_FMT_I;
                if (w_f3 == 3'b000) w_op = 6'd4;
            end
            c_OPC_BRANCH: begin
                w_fmt = c_FMT_B;
                case (w_f3)
                    3'b000:  w_op = 6'd5;
                    3'b001:  w_op = 6'd6;
                    3'b100:  w_op = 6'd7;
                    3'b101:  w_op = 6'd8;
                    3'b110:  w_op = 6'd9;
                    3'b111:  w_op = 6'd10;
                    default: ;
                endcase
            end
            c_OPC_LOAD: begin
                w_fmt = c_FMT_I;
                case (w_f3)
                    3'b000:  w_op = 6'd11;
                    3'b001:  w_op = 6'd12;
                    3'b010:  w_op = 6'd13;
                    3'b100:  w_op = 6'd14;
                    3'b101:  w_op = 6'd15;
                    default: ;
                endcase
            end
            c_OPC_STORE: begin
                w_fmt = c_FMT_S;
                case (w_f3)
                    3'b000:  w_op = 6'd16;
                    3'b001:  w_op = 6'd17;
                    3'b010:  w_op = 6'd18;
                    default: ;
                endcase
            end
            c_OPC_OPIMM: begin
                w_fmt = c_FMT_I;
                case (w_f3)
                    3'b000: w_op = 6'd19;
                    3'b010: w_op = 6'd20;
                    3'b011: w_op = 6'd21;
                    3'b100: w_op = 6'd22;
                    3'b110: w_op = 6'd23;
                    3'b111: w_op = 6'd24;
                    3'b001: begin
                        w_fmt = c_FMT_SH;
                        if (w_f7 == 7'b0000000) w_op = 6'd25;
                    end
                    default: begin
                        w_fmt = c_FMT_SH;
                        if (w_f7 == 7'b0000000)      w_op = 6'd26;
                        else if (w_f7 == 7'b0100000) w_op = 6'd27;
                    end
                endcase
            end
            c_OPC_OP: begin
                w_fmt = c_FMT_R;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_op = 6'd28;
                        3'b001:  w_op = 6'd30;
                        3'b010:  w_op = 6'd31;
                        3'b011:  w_op = 6'd32;
                        3'b100:  w_op = 6'd33;
                        3'b101:  w_op = 6'd34;
                        3'b110:  w_op = 6'd36;
                        default: w_op = 6'd37;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000)      w_op = 6'd29;
                    else if (w_f3 == 3'b101) w_op = 6'd35;
                end else if (w_f7 == 7'b0000001 && ENABLE_M != 0) begin
                    w_op = 6'd38 + {3'd0, w_f3};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_entry         = '0;
        w_entry.tag     = bus.in_tag;
        w_entry.illegal = (w_op == 6'd0);
        if (w_op != 6'd0) begin
            w_entry.op = w_op;
            case (w_fmt)
                c_FMT_R:  begin w_entry.rd = w_instr[11:7]; w_entry.rs1 = w_instr[19:15]; w_entry.rs2 = w_instr[24:20]; end
                c_FMT_I:  begin w_entry.rd = w_instr[11:7]; w_entry.rs1 = w_instr[19:15]; w_entry.imm = w_imm_i; end
                c_FMT_SH: begin w_entry.rd = w_instr[11:7]; w_entry.rs1 = w_instr[19:15]; w_entry.imm = w_imm_sh; end
                c_FMT_S:  begin w_entry.rs1 = w_instr[19:15]; w_entry.rs2 = w_instr[24:20]; w_entry.imm = w_imm_s; end
                c_FMT_B:  begin w_entry.rs1 = w_instr[19:15]; w_entry.rs2 = w_instr[24:20]; w_entry.imm = w_imm_b; end
                c_FMT_U:  begin w_entry.rd = w_instr[11:7]; w_entry.imm = w_imm_u; end
                c_FMT_J:  begin w_entry.rd = w_instr[11:7]; w_entry.imm = w_imm_j; end
                default:  ;
            endcase
        end
    end

    // in_ready deliberately ignores a same-cycle pop
    assign w_ready = (r_count != c_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = bus.in_valid && w_ready && !flush;
    assign w_pop   = w_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.in_ready    = w_ready;
    assign bus.out_valid   = w_valid;
    assign bus.out_op      = w_head.op;
    assign bus.out_rd      = w_head.rd;
    assign bus.out_rs1     = w_head.rs1;
    assign bus.out_rs2     = w_head.rs2;
    assign bus.out_imm     = w_head.imm;
    assign bus.out_illegal = w_head.illegal;
    assign bus.out_tag     = w_head.tag;
endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_pipe
//  Brief    : Three decoder_pipe configurations driven in lockstep vs a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_pipe;
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        int  opc;
        int  f3;
        int  f7;
        int  op;
        byte fmt;
    } rule_t;

    logic        clk, rst, flush;
    logic        s_valid, s_ready;
    logic [31:0] s_instr, s_tag;
    int          n_chk = 0;
    int          n_err = 0;
    rule_t       rules[$];
    exp_t        q_a[$], q_b[$], q_c[$];

    decoder_pipe_if #(.TAG_W(32)) if_a ();
    decoder_pipe_if #(.TAG_W(32)) if_b ();
    decoder_pipe_if #(.TAG_W(32)) if_c ();

    decoder_pipe #(.DEPTH(2), .TAG_W(32), .ENABLE_M(1)) dut_a (.clk(clk), .rst(rst), .flush(flush), .bus(if_a));
    decoder_pipe #(.DEPTH(2), .TAG_W(32), .ENABLE_M(0)) dut_b (.clk(clk), .rst(rst), .flush(flush), .bus(if_b));
    decoder_pipe #(.DEPTH(4), .TAG_W(32), .ENABLE_M(1)) dut_c (.clk(clk), .rst(rst), .flush(flush), .bus(if_c));

    assign if_a.in_valid = s_valid; assign if_a.in_instr = s_instr; assign if_a.in_tag = s_tag; assign if_a.out_ready = s_ready;
    assign if_b.in_valid = s_valid; assign if_b.in_instr = s_instr; assign if_b.in_tag = s_tag; assign if_b.out_ready = s_ready;
    assign if_c.in_valid = s_valid; assign if_c.in_instr = s_instr; assign if_c.in_tag = s_tag; assign if_c.out_ready = s_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(int opc, int f3, int f7, int op, byte fmt);
        rules.push_back('{opc, f3, f7, op, fmt});
    endfunction

    function automatic void build_rules();
        int bf[6] = '{0, 1, 4, 5, 6, 7};
        int lf[5] = '{0, 1, 2, 4, 5};
        int af[6] = '{0, 2, 3, 4, 6, 7};
        int ro[8] = '{28, 30, 31, 32, 33, 34, 36, 37};
        add(7'h37, -1, -1, 1, "U");
        add(7'h17, -1, -1, 2, "U");
        add(7'h6F, -1, -1, 3, "J");
        add(7'h67, 0, -1, 4, "I");
        for (int i = 0; i < 6; i++) add(7'h63, bf[i], -1, 5 + i, "B");
        for (int i = 0; i < 5; i++) add(7'h03, lf[i], -1, 11 + i, "I");
        for (int i = 0; i < 3; i++) add(7'h23, i, -1, 16 + i, "S");
        for (int i = 0; i < 6; i++) add(7'h13, af[i], -1, 19 + i, "I");
        add(7'h13, 1, 0, 25, "H");
        add(7'h13, 5, 0, 26, "H");
        add(7'h13, 5, 32, 27, "H");
        for (int i = 0; i < 8; i++) add(7'h33, i, 0, ro[i], "R");
        add(7'h33, 0, 32, 29, "R");
        add(7'h33, 5, 32, 35, "R");
        for (int i = 0; i < 8; i++) add(7'h33, i, 1, 38 + i, "R");
    endfunction

    // Reference decode: table lookup plus arithmetic immediate reconstruction
    function automatic exp_t ref_decode(logic [31:0] w, bit m_en);
        exp_t e = '0;
        int   s;
        e.ill = 1'b1;
        foreach (rules[i]) begin
            if (rules[i].opc == int'(w[6:0]) &&
                (rules[i].f3 < 0 || rules[i].f3 == int'(w[14:12])) &&
                (rules[i].f7 < 0 || rules[i].f7 == int'(w[31:25])) &&
                (m_en || rules[i].op < 38)) begin
                byte f = rules[i].fmt;
                e.op  = 6'(rules[i].op);
                e.ill = 1'b0;
                if (f inside {"R", "I", "H", "U", "J"}) e.rd  = w[11:7];
                if (f inside {"R", "I", "H", "S", "B"}) e.rs1 = w[19:15];
                if (f inside {"R", "S", "B"})           e.rs2 = w[24:20];
                s = 0;
                if (f == "I") s = int'($signed(w) >>> 20);
                if (f == "H") s = int'(w[24:20]);
                if (f == "S") s = int'($signed(w) >>> 25) * 32 + int'(w[11:7]);
                if (f == "B") s = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
                if (f == "U") s = int'(w & 32'hFFFFF000);
                if (f == "J") s = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
                e.imm = 32'(s);
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(logic [31:0] w, logic [31:0] t, bit m_en);
        exp_t e = ref_decode(w, m_en);
        e.tag = t;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int          k;
        if ($urandom_range(0, 5) == 0) return w;
        k = $urandom_range(0, rules.size() - 1);
        w[6:0] = 7'(rules[k].opc);
        if (rules[k].f3 >= 0) w[14:12] = 3'(rules[k].f3);
        if (rules[k].f7 >= 0) w[31:25] = 7'(rules[k].f7);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string n, input int depth, input int sz, input exp_t h,
                             input logic rdy, input logic vld, input logic [5:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic ill, input logic [31:0] tag);
        chk({n, ".in_ready"}, 32'(rdy), 32'(sz < depth));
        chk({n, ".out_valid"}, 32'(vld), 32'(sz > 0));
        if (sz > 0) begin
            chk({n, ".op"}, 32'(op), 32'(h.op));
            chk({n, ".rd"}, 32'(rd), 32'(h.rd));
            chk({n, ".rs1"}, 32'(rs1), 32'(h.rs1));
            chk({n, ".rs2"}, 32'(rs2), 32'(h.rs2));
            chk({n, ".imm"}, imm, h.imm);
            chk({n, ".illegal"}, 32'(ill), 32'(h.ill));
            chk({n, ".tag"}, tag, h.tag);
        end
    endtask

    task automatic check_all();
        check_dut("a", 2, q_a.size(), q_a.size() > 0 ? q_a[0] : exp_t'(0), if_a.in_ready, if_a.out_valid,
                  if_a.out_op, if_a.out_rd, if_a.out_rs1, if_a.out_rs2, if_a.out_imm, if_a.out_illegal, if_a.out_tag);
        check_dut("b", 2, q_b.size(), q_b.size() > 0 ? q_b[0] : exp_t'(0), if_b.in_ready, if_b.out_valid,
                  if_b.out_op, if_b.out_rd, if_b.out_rs1, if_b.out_rs2, if_b.out_imm, if_b.out_illegal, if_b.out_tag);
        check_dut("c", 4, q_c.size(), q_c.size() > 0 ? q_c[0] : exp_t'(0), if_c.in_ready, if_c.out_valid,
                  if_c.out_op, if_c.out_rd, if_c.out_rs1, if_c.out_rs2, if_c.out_imm, if_c.out_illegal, if_c.out_tag);
    endtask

    task automatic check_rst(input string n, input logic rdy, input logic vld, input logic [5:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic ill, input logic [31:0] tag);
        chk({n, ".rst.in_ready"}, 32'(rdy), 32'd1);
        chk({n, ".rst.out_valid"}, 32'(vld), 32'd0);
        chk({n, ".rst.op"}, 32'(op), 32'd0);
        chk({n, ".rst.regs"}, {17'd0, rd, rs1, rs2}, 32'd0);
        chk({n, ".rst.imm"}, imm, 32'd0);
        chk({n, ".rst.illegal"}, 32'(ill), 32'd0);
        chk({n, ".rst.tag"}, tag, 32'd0);
    endtask

    task automatic check_rst_all();
        check_rst("a", if_a.in_ready, if_a.out_valid, if_a.out_op, if_a.out_rd, if_a.out_rs1, if_a.out_rs2, if_a.out_imm, if_a.out_illegal, if_a.out_tag);
        check_rst("b", if_b.in_ready, if_b.out_valid, if_b.out_op, if_b.out_rd, if_b.out_rs1, if_b.out_rs2, if_b.out_imm, if_b.out_illegal, if_b.out_tag);
        check_rst("c", if_c.in_ready, if_c.out_valid, if_c.out_op, if_c.out_rd, if_c.out_rs1, if_c.out_rs2, if_c.out_imm, if_c.out_illegal, if_c.out_tag);
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] t, input bit rdy, input bit fl);
        bit pa, pb, pc, xa, xb, xc;
        s_valid = v; s_instr = w; s_tag = t; s_ready = rdy; flush = fl;
        pa = v && q_a.size() < 2 && !fl; xa = q_a.size() > 0 && rdy && !fl;
        pb = v && q_b.size() < 2 && !fl; xb = q_b.size() > 0 && rdy && !fl;
        pc = v && q_c.size() < 4 && !fl; xc = q_c.size() > 0 && rdy && !fl;
        @(posedge clk);
        if (fl) begin
            q_a.delete(); q_b.delete(); q_c.delete();
        end else begin
            if (xa) void'(q_a.pop_front());
            if (xb) void'(q_b.pop_front());
            if (xc) void'(q_c.pop_front());
            if (pa) q_a.push_back(mk(w, t, 1'b1));
            if (pb) q_b.push_back(mk(w, t, 1'b0));
            if (pc) q_c.push_back(mk(w, t, 1'b1));
        end
        #1;
        check_all();
    endtask

    initial begin
        build_rules();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_instr = '0; s_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check_rst_all();
        #1 rst = 1'b0;

        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        chk("addi.op", 32'(if_a.out_op), 32'd19);
        chk("addi.rd", 32'(if_a.out_rd), 32'd1);
        chk("addi.imm", if_a.out_imm, 32'd5);
        chk("addi.tag", if_a.out_tag, 32'h100);
        step(1'b1, 32'hFE208EE3, 32'h104, 1'b1, 1'b0);
        chk("beq.op", 32'(if_a.out_op), 32'd5);
        chk("beq.regs", {17'd0, if_a.out_rd, if_a.out_rs1, if_a.out_rs2}, {17'd0, 5'd0, 5'd1, 5'd2});
        chk("beq.imm", if_a.out_imm, 32'hFFFFFFFC);
        step(1'b1, 32'h40115193, 32'h108, 1'b1, 1'b0);
        chk("srai.op", 32'(if_a.out_op), 32'd27);
        chk("srai.imm", if_a.out_imm, 32'd1);
        step(1'b1, 32'h022081B3, 32'h10C, 1'b1, 1'b0);
        chk("mul.op", 32'(if_a.out_op), 32'd38);
        chk("mul.regs", {17'd0, if_a.out_rd, if_a.out_rs1, if_a.out_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
        chk("mul_nom.op", 32'(if_b.out_op), 32'd0);
        chk("mul_nom.illegal", 32'(if_b.out_illegal), 32'd1);
        chk("mul_nom.imm", if_b.out_imm, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // back-pressure: third word held while DEPTH=2 is full
        step(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'hFE208EE3, 32'h204, 1'b0, 1'b0);
        chk("full.in_ready", 32'(if_a.in_ready), 32'd0);
        step(1'b1, 32'h022081B3, 32'h208, 1'b0, 1'b0);
        chk("full.head_tag", if_a.out_tag, 32'h200);
        step(1'b1, 32'h022081B3, 32'h208, 1'b1, 1'b0);
        chk("pop1.in_ready", 32'(if_a.in_ready), 32'd1);
        chk("pop1.head_tag", if_a.out_tag, 32'h204);
        step(1'b1, 32'h022081B3, 32'h208, 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0, 1'b0);
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        step(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'hFE208EE3, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'h40115193, 32'h308, 1'b0, 1'b1);
        chk("flush.out_valid", 32'(if_a.out_valid), 32'd0);
        chk("flush.in_ready", 32'(if_a.in_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset landing mid-cycle with data buffered
        step(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'hFE208EE3, 32'h404, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_rst_all();
        q_a.delete(); q_b.delete(); q_c.delete();
        s_valid = 1'b0; s_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h00500093, 32'h500, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
